// File: rtl/sample_window_queue_if.sv
// Sample-in / burst-out bus of the equalizer sample window queue.
// SWQ_FLUSH_EN adds the synchronous flush request to the bus.
interface sample_window_queue_if #(
  parameter int DATA_W = 16,
  parameter int PTR_W  = 11
);
  logic [DATA_W-1:0] new_smpl;
  logic              smpl_vld;
  logic              clr_ovr;
  logic [DATA_W-1:0] smpl_out;
  logic              sequencing;
  logic              frst;
  logic              lst;
  logic [PTR_W:0]    fill_cnt;
  logic              overrun;
`ifdef SWQ_FLUSH_EN
  logic              flush;

  modport master (
    output new_smpl, smpl_vld, clr_ovr, flush,
    input  smpl_out, sequencing, frst, lst, fill_cnt, overrun
  );
  modport slave (
    input  new_smpl, smpl_vld, clr_ovr, flush,
    output smpl_out, sequencing, frst, lst, fill_cnt, overrun
  );
`else
  modport master (
    output new_smpl, smpl_vld, clr_ovr,
    input  smpl_out, sequencing, frst, lst, fill_cnt, overrun
  );
  modport slave (
    input  new_smpl, smpl_vld, clr_ovr,
    output smpl_out, sequencing, frst, lst, fill_cnt, overrun
  );
`endif
endinterface

// File: rtl/sample_window_queue.sv
// Circular sample queue: every sample past WINDOW replays the newest WINDOW samples, oldest first.
// Optional SWQ_FLUSH_EN: synchronous flush of fill count, write pointer and pending burst.
module sample_window_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1536,
  parameter int WINDOW = 1021,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  rst_n,
  sample_window_queue_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] WIN_OFFS  = PTR_W'(WINDOW - 1);
  localparam logic [PTR_W-1:0] WRAP_ADD  = PTR_W'(DEPTH - WINDOW + 1);
  localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FILL_MAX  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   FILL_TRIG = (PTR_W+1)'(WINDOW - 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] ram_q_r;
  logic [DATA_W-1:0] smpl_out_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  rd_cnt_r;
  logic [PTR_W-1:0]  pend_start_r;
  logic [PTR_W:0]    fill_cnt_r;
  logic [1:0]        state_r;
  logic              pending_r;
  logic              overrun_r;
  logic              rd_vld_r;
  logic              rd_frst_r;
  logic              rd_lst_r;
  logic              sequencing_r;
  logic              frst_r;
  logic              lst_r;
  logic              flush_s;
  logic              wr_en_s;
  logic              trig_s;
  logic [PTR_W-1:0]  start_s;

`ifdef SWQ_FLUSH_EN
  assign flush_s = bus.flush;
`else
  assign flush_s = 1'b0;
`endif

  // Write qualification, trigger detection and wrap-correct burst start address.
  always_comb begin
    wr_en_s = bus.smpl_vld & ~flush_s;
    trig_s  = wr_en_s & (fill_cnt_r >= FILL_TRIG);
    if (wr_ptr_r >= WIN_OFFS) begin
      start_s = wr_ptr_r - WIN_OFFS;
    end else begin
      start_s = wr_ptr_r + WRAP_ADD;
    end
  end

  // Sample RAM: write port on every accepted strobe, registered read port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= bus.new_smpl;
    end
    ram_q_r <= mem_r[rd_ptr_r];
  end

  // Write pointer and saturating fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      fill_cnt_r <= '0;
    end else if (flush_s) begin
      wr_ptr_r   <= '0;
      fill_cnt_r <= '0;
    end else if (wr_en_s) begin
      wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + PTR_ONE;
      if (fill_cnt_r != FILL_MAX) begin
        fill_cnt_r <= fill_cnt_r + FILL_ONE;
      end
    end
  end

  // Burst sequencer; a queued burst leaves DRAIN straight into READ so only one idle output cycle separates bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rd_ptr_r     <= '0;
      rd_cnt_r     <= '0;
      pending_r    <= 1'b0;
      pend_start_r <= '0;
    end else if (flush_s) begin
      state_r   <= ST_IDLE;
      pending_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pending_r) begin
            rd_ptr_r  <= pend_start_r;
            rd_cnt_r  <= '0;
            pending_r <= 1'b0;
            state_r   <= ST_READ;
          end else if (trig_s) begin
            rd_ptr_r <= start_s;
            rd_cnt_r <= '0;
            state_r  <= ST_READ;
          end
        end
        ST_READ: begin
          rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + PTR_ONE;
          rd_cnt_r <= rd_cnt_r + PTR_ONE;
          if (rd_cnt_r == WIN_OFFS) begin
            state_r <= ST_DRAIN;
          end
          if (trig_s && !pending_r) begin
            pending_r    <= 1'b1;
            pend_start_r <= start_s;
          end
        end
        ST_DRAIN: begin
          if (pending_r) begin
            rd_ptr_r  <= pend_start_r;
            rd_cnt_r  <= '0;
            pending_r <= 1'b0;
            state_r   <= ST_READ;
          end else begin
            state_r <= ST_IDLE;
            if (trig_s) begin
              pending_r    <= 1'b1;
              pend_start_r <= start_s;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a trigger that finds a burst already queued is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (trig_s && pending_r) begin
      overrun_r <= 1'b1;
    end else if (bus.clr_ovr) begin
      overrun_r <= 1'b0;
    end
  end

  // Read pipeline: tag each RAM read, then register the framed, zero-gated output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_r     <= 1'b0;
      rd_frst_r    <= 1'b0;
      rd_lst_r     <= 1'b0;
      sequencing_r <= 1'b0;
      frst_r       <= 1'b0;
      lst_r        <= 1'b0;
      smpl_out_r   <= '0;
    end else if (flush_s) begin
      rd_vld_r     <= 1'b0;
      rd_frst_r    <= 1'b0;
      rd_lst_r     <= 1'b0;
      sequencing_r <= 1'b0;
      frst_r       <= 1'b0;
      lst_r        <= 1'b0;
      smpl_out_r   <= '0;
    end else begin
      rd_vld_r     <= (state_r == ST_READ);
      rd_frst_r    <= (rd_cnt_r == '0);
      rd_lst_r     <= (rd_cnt_r == WIN_OFFS);
      sequencing_r <= rd_vld_r;
      frst_r       <= rd_vld_r & rd_frst_r;
      lst_r        <= rd_vld_r & rd_lst_r;
      smpl_out_r   <= rd_vld_r ? ram_q_r : '0;
    end
  end

  assign bus.smpl_out   = smpl_out_r;
  assign bus.sequencing = sequencing_r;
  assign bus.frst       = frst_r;
  assign bus.lst        = lst_r;
  assign bus.fill_cnt   = fill_cnt_r;
  assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_sample_window_queue.sv
// Directed bench for sample_window_queue with DEPTH=8, WINDOW=4.
// Define SWQ_FLUSH_EN for both RTL and bench to include the flush scenario.
module tb_sample_window_queue;
  localparam logic [18:0] IDL = 19'd0;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sample_window_queue_if #(.DATA_W(16), .PTR_W(3)) bus ();

  sample_window_queue #(.DATA_W(16), .DEPTH(8), .WINDOW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {sequencing, frst, lst, smpl_out} for one burst cycle.
  function automatic logic [18:0] frm(input logic fr, input logic ls, input int d);
    return {1'b1, fr, ls, 16'(d)};
  endfunction

  task automatic drive_smpl(input int v);
    bus.new_smpl = 16'(v);
    bus.smpl_vld = 1'b1;
    @(negedge clk);
    bus.smpl_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.smpl_vld = 1'b0;
    bus.new_smpl = 16'd0;
    bus.clr_ovr  = 1'b0;
`ifdef SWQ_FLUSH_EN
    bus.flush    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    total++;
    if ({bus.sequencing, bus.frst, bus.lst, bus.overrun} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b exp 0000", {bus.sequencing, bus.frst, bus.lst, bus.overrun});
    end
    total++;
    if (bus.smpl_out !== 16'd0) begin
      bad++;
      $display("FAIL reset_smpl_out: got %h exp 0000", bus.smpl_out);
    end
    total++;
    if (bus.fill_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_fill_cnt: got %0d exp 0", bus.fill_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_burst();
    logic [18:0] got;
    logic [18:0] exp;
    for (int v = 1; v <= 3; v++) drive_smpl(v);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.sequencing !== 1'b0) begin
        bad++;
        $display("FAIL underfill_seq[%0d]: got %b exp 0", k, bus.sequencing);
      end
    end
    total++;
    if (bus.fill_cnt !== 4'd3) begin
      bad++;
      $display("FAIL underfill_cnt: got %0d exp 3", bus.fill_cnt);
    end
    drive_smpl(4);
    @(negedge clk);
    total++;
    if (bus.sequencing !== 1'b0) begin
      bad++;
      $display("FAIL first_latency: got %b exp 0", bus.sequencing);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = {bus.sequencing, bus.frst, bus.lst, bus.smpl_out};
      exp = frm(i == 0, i == 3, i + 1);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL first_burst[%0d]: got %h exp %h", i, got, exp);
      end
    end
    @(negedge clk);
    got = {bus.sequencing, bus.frst, bus.lst, bus.smpl_out};
    total++;
    if (got !== IDL) begin
      bad++;
      $display("FAIL first_burst_end: got %h exp %h", got, IDL);
    end
  endtask

  task automatic test_wrap();
    logic [18:0] got;
    logic [18:0] exp;
    for (int v = 5; v <= 12; v++) begin
      drive_smpl(v);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        got = {bus.sequencing, bus.frst, bus.lst, bus.smpl_out};
        exp = frm(i == 0, i == 3, v - 3 + i);
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL wrap_burst_%0d[%0d]: got %h exp %h", v, i, got, exp);
        end
      end
      repeat (2) @(negedge clk);
      total++;
      if (bus.sequencing !== 1'b0) begin
        bad++;
        $display("FAIL wrap_idle_%0d: got %b exp 0", v, bus.sequencing);
      end
    end
    total++;
    if (bus.fill_cnt !== 4'd8) begin
      bad++;
      $display("FAIL wrap_fill_sat: got %0d exp 8", bus.fill_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] got;
    logic [18:0] exp_q [$];
    do_reset();
    for (int v = 1; v <= 4; v++) drive_smpl(v);
    exp_q = {IDL, frm(1'b1, 1'b0, 1), frm(1'b0, 1'b0, 2), frm(1'b0, 1'b0, 3), frm(1'b0, 1'b1, 4),
             IDL, frm(1'b1, 1'b0, 2), frm(1'b0, 1'b0, 3), frm(1'b0, 1'b0, 4), frm(1'b0, 1'b1, 5), IDL};
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = {bus.sequencing, bus.frst, bus.lst, bus.smpl_out};
      total++;
      if (got !== exp_q[k]) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %h exp %h", k, got, exp_q[k]);
      end
      bus.new_smpl = 16'd5;
      bus.smpl_vld = (k == 2);
    end
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back_ovr: got %b exp 0", bus.overrun);
    end
  endtask

  task automatic test_overrun();
    logic [18:0] got;
    logic [18:0] exp_q [$];
    do_reset();
    for (int v = 1; v <= 4; v++) drive_smpl(v);
    exp_q = {IDL, frm(1'b1, 1'b0, 1), frm(1'b0, 1'b0, 2), frm(1'b0, 1'b0, 3), frm(1'b0, 1'b1, 4),
             IDL, frm(1'b1, 1'b0, 2), frm(1'b0, 1'b0, 3), frm(1'b0, 1'b0, 4), frm(1'b0, 1'b1, 5),
             IDL, IDL, IDL};
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = {bus.sequencing, bus.frst, bus.lst, bus.smpl_out};
      total++;
      if (got !== exp_q[k]) begin
        bad++;
        $display("FAIL overrun_burst[%0d]: got %h exp %h", k, got, exp_q[k]);
      end
      bus.new_smpl = (k == 1) ? 16'd5 : 16'd6;
      bus.smpl_vld = (k == 1) || (k == 2);
      bus.clr_ovr  = (k == 2);
    end
    total++;
    if (bus.overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set_wins: got %b exp 1", bus.overrun);
    end
    bus.clr_ovr = 1'b1;
    @(negedge clk);
    bus.clr_ovr = 1'b0;
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: got %b exp 0", bus.overrun);
    end
    drive_smpl(7);
    exp_q = {IDL, frm(1'b1, 1'b0, 4), frm(1'b0, 1'b0, 5), frm(1'b0, 1'b0, 6), frm(1'b0, 1'b1, 7), IDL};
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = {bus.sequencing, bus.frst, bus.lst, bus.smpl_out};
      total++;
      if (got !== exp_q[k]) begin
        bad++;
        $display("FAIL overrun_next[%0d]: got %h exp %h", k, got, exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [18:0] got;
    do_reset();
    for (int v = 1; v <= 4; v++) drive_smpl(v);
    repeat (4) @(negedge clk);
    got = {bus.sequencing, bus.frst, bus.lst, bus.smpl_out};
    total++;
    if (got !== frm(1'b0, 1'b0, 3)) begin
      bad++;
      $display("FAIL mid_third_out: got %h exp %h", got, frm(1'b0, 1'b0, 3));
    end
    rst_n = 1'b0;
    #1;
    got = {bus.sequencing, bus.frst, bus.lst, bus.smpl_out};
    total++;
    if (got !== IDL) begin
      bad++;
      $display("FAIL mid_reset_out: got %h exp %h", got, IDL);
    end
    total++;
    if (bus.fill_cnt !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset_fill: got %0d exp 0", bus.fill_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int v = 10; v <= 12; v++) drive_smpl(v);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (bus.sequencing !== 1'b0) begin
        bad++;
        $display("FAIL mid_refill_seq[%0d]: got %b exp 0", k, bus.sequencing);
      end
    end
    total++;
    if (bus.fill_cnt !== 4'd3) begin
      bad++;
      $display("FAIL mid_refill_cnt: got %0d exp 3", bus.fill_cnt);
    end
  endtask

`ifdef SWQ_FLUSH_EN
  task automatic test_flush();
    logic [18:0] got;
    logic [18:0] exp_q [$];
    do_reset();
    for (int v = 1; v <= 4; v++) drive_smpl(v);
    repeat (2) @(negedge clk);
    got = {bus.sequencing, bus.frst, bus.lst, bus.smpl_out};
    total++;
    if (got !== frm(1'b1, 1'b0, 1)) begin
      bad++;
      $display("FAIL flush_pre: got %h exp %h", got, frm(1'b1, 1'b0, 1));
    end
    bus.flush    = 1'b1;
    bus.new_smpl = 16'd99;
    bus.smpl_vld = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.smpl_vld = 1'b0;
    got = {bus.sequencing, bus.frst, bus.lst, bus.smpl_out};
    total++;
    if (got !== IDL) begin
      bad++;
      $display("FAIL flush_drop: got %h exp %h", got, IDL);
    end
    total++;
    if (bus.fill_cnt !== 4'd0) begin
      bad++;
      $display("FAIL flush_fill: got %0d exp 0", bus.fill_cnt);
    end
    for (int v = 20; v <= 22; v++) drive_smpl(v);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (bus.sequencing !== 1'b0) begin
        bad++;
        $display("FAIL flush_refill_seq[%0d]: got %b exp 0", k, bus.sequencing);
      end
    end
    drive_smpl(23);
    exp_q = {IDL, frm(1'b1, 1'b0, 20), frm(1'b0, 1'b0, 21), frm(1'b0, 1'b0, 22), frm(1'b0, 1'b1, 23), IDL};
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = {bus.sequencing, bus.frst, bus.lst, bus.smpl_out};
      total++;
      if (got !== exp_q[k]) begin
        bad++;
        $display("FAIL flush_next[%0d]: got %h exp %h", k, got, exp_q[k]);
      end
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_first_burst();
    test_wrap();
    test_back_to_back();
    test_overrun();
    test_reset_mid_burst();
`ifdef SWQ_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
